riscv_dcache: RTL and testbench
===============================

Name: riscv_dcache

Overview:
- Data-cache responder that sits on the core's dcache_* interface and serves the LSU's load/store requests.
- Organisation: direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
- Misses and all stores go to a simple word-wide memory port.
- Provides a bulk-invalidate sweep, used after reset and on request.

Parameters:
- LINES, 64, number of cache lines; power of two, at least 2.
- IDX_W, $clog2(LINES), index width (derived; not overridden).

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous, active-high reset.
- dcache_read_request  in  1  load request from the core.
- dcache_write_request  in  4  store byte enables; nonzero means a store.
- dcache_addr  in  32  byte address; bits [1:0] ignored.
- dcache_wdata  in  32  store data.
- dcache_accept  out  1  request taken this cycle.
- dcache_busy  out  1  block is not in IDLE.
- dcache_rdata_valid  out  1  one-cycle pulse; dcache_rdata is valid.
- dcache_wdata_valid  out  1  one-cycle pulse; store is complete in memory.
- dcache_rdata  out  32  load data.
- dcache_invalidate  in  1  pulse requesting invalidation of all lines.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_be  out  4  write byte enables.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory accepted the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Address split: tag = addr[31:2+IDX_W], index = addr[2+IDX_W-1:2]. Arrays: valid[LINES], tag[LINES], data[LINES]. Data array has registered read.
- Reset: state=INIT, sweep counter=0. All outputs 0, except dcache_busy=1.
- FSM states: INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP, WR_REQ, WR_DONE.
- INIT:
  - clears valid[counter] each cycle; counter increments.
  - goes to IDLE after the cycle that clears line LINES-1, i.e. LINES cycles.
  - counter wraps to 0.
- IDLE:
  - invalidate: a latched pending invalidate has priority over new requests and enters INIT.
  - dcache_accept = (read_request | write_request!=0) & no pending invalidate; combinational, same cycle.
  - accepted store → WR_REQ; accepted load → LOOKUP.
  - read and write both requested: store wins, load is not accepted.
  - addr, wdata and be are latched on accept.
- LOOKUP: hit (valid & tag match) → RESP with array data; miss → MISS_REQ.
- MISS_REQ:
  - drives mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}.
  - on mem_ack → MISS_WAIT.
- MISS_WAIT: on mem_rvalid, fills the line (valid=1, tag, data=mem_rdata), captures rdata → RESP.
- RESP: dcache_rdata_valid=1 for one cycle → IDLE.
- Load latency from accept to rdata_valid: hit = 2 cycles; miss = 3 + memory latency.
- dcache_rdata holds its value until the next RESP.
- WR_REQ:
  - drives mem_req=1, mem_we=1, mem_be=latched be, mem_wdata.
  - on mem_ack: if hit, merge the enabled bytes into the line → WR_DONE.
  - on a miss, the array is untouched.
- WR_DONE: dcache_wdata_valid=1 for one cycle → IDLE.
- dcache_busy = (state != IDLE).
- dcache_invalidate:
  - in IDLE it enters INIT next cycle.
  - otherwise it sets a pending flag that is serviced on the return to IDLE.
  - multiple pulses collapse into one sweep.
- mem_rvalid outside MISS_WAIT and mem_ack outside MISS_REQ/WR_REQ are ignored.
- srst mid-operation:
  - returns to INIT the next cycle and drops mem_req.
  - the outstanding memory transaction is abandoned; its later responses are ignored.
- Outputs to the core (accept, rdata_valid, wdata_valid) never assert during INIT.

Decomposition:
- Shared package riscv_def:
  - state encoding constants DC_INIT..DC_WR_DONE.
  - MEM_BE_W=4.
- One natural sub-module: riscv_dcache_array, holding valid/tag/data storage.
  - one write port with per-byte enables.
  - registered read port.
  - single-cycle valid clear by index.
- FSM and tag compare stay in the top.

Test Plan:
- Post-reset: dcache_busy=1 for exactly 64 cycles (LINES=64), dcache_accept=0 throughout, then busy=0.
- Load miss 0x100, memory returns 0xDEADBEEF after 3 cycles → mem_addr=0x100, we=0, single mem_req; rdata_valid pulse with 0xDEADBEEF at 6 cycles after accept.
- Repeat load 0x100 → no mem_req; rdata_valid 2 cycles after accept with 0xDEADBEEF.
- Store be=4'b0011, wdata=0x12345678 to 0x100 → mem_be=0011, mem_wdata=0x12345678; wdata_valid one cycle after mem_ack; next load hits and returns 0xDEAD5678.
- Load 0x200 (same index, different tag) → miss and fill; subsequent load 0x100 misses again.
- Invalidate pulse during MISS_WAIT → load completes, then 64-cycle sweep; load 0x200 misses; a spurious mem_rvalid in IDLE changes nothing.

Source files
------------

// File: rtl/riscv_dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM state encoding and memory-port widths.
package riscv_def;

  typedef logic [2:0] dc_state_t;

  localparam dc_state_t DC_INIT      = 3'd0;
  localparam dc_state_t DC_IDLE      = 3'd1;
  localparam dc_state_t DC_LOOKUP    = 3'd2;
  localparam dc_state_t DC_MISS_REQ  = 3'd3;
  localparam dc_state_t DC_MISS_WAIT = 3'd4;
  localparam dc_state_t DC_RESP      = 3'd5;
  localparam dc_state_t DC_WR_REQ    = 3'd6;
  localparam dc_state_t DC_WR_DONE   = 3'd7;

  localparam int MEM_BE_W = 4;
  localparam int WORD_W   = 32;

endpackage

// File: rtl/riscv_dcache_array.sv
// Valid/tag/data storage for the data cache: one byte-enabled write port,
// a registered read port and a single-line valid clear used by the sweep.
module riscv_dcache_array
  import riscv_def::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [WORD_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [MEM_BE_W-1:0] wr_be,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                clr_en,
  input  logic [IDX_W-1:0]    clr_idx
);

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem [LINES];

  // Clear and write never coincide: clears happen only while sweeping.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_reg[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
    rd_valid <= valid_reg[rd_idx];
    rd_tag   <= tag_mem[rd_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < MEM_BE_W; gi++) begin : g_byte
      logic [7:0] byte_mem [LINES];
      logic [7:0] byte_q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          byte_mem[wr_idx] <= wr_data[8*gi +: 8];
        end
        byte_q_reg <= byte_mem[rd_idx];
      end

      assign rd_data[8*gi +: 8] = byte_q_reg;
    end
  endgenerate

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache
// between the LSU dcache_* interface and a word-wide memory port.
module riscv_dcache
  import riscv_def::*;
#(
  parameter  int LINES = 64,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                dcache_read_request,
  input  logic [MEM_BE_W-1:0] dcache_write_request,
  input  logic [31:0]         dcache_addr,
  input  logic [31:0]         dcache_wdata,
  output logic                dcache_accept,
  output logic                dcache_busy,
  output logic                dcache_rdata_valid,
  output logic                dcache_wdata_valid,
  output logic [31:0]         dcache_rdata,
  input  logic                dcache_invalidate,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MEM_BE_W-1:0] mem_be,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata
);

  localparam int TAG_W = 30 - IDX_W;

  dc_state_t           state_reg, state_next;
  logic [IDX_W-1:0]    cnt_reg;
  logic                inv_pend_reg;
  logic [29:0]         waddr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         rdata_reg;
  logic [MEM_BE_W-1:0] be_reg;

  logic                is_store, is_load, inv_any, hit;
  logic [IDX_W-1:0]    rd_idx;
  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  logic [31:0]         arr_data;
  logic                wr_en;
  logic [MEM_BE_W-1:0] wr_be;
  logic [31:0]         wr_data;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^dcache_addr[1:0];

  assign is_store = |dcache_write_request;
  assign is_load  = dcache_read_request;
  assign inv_any  = inv_pend_reg | dcache_invalidate;
  assign hit      = arr_valid && (arr_tag == waddr_reg[29:IDX_W]);

  // In IDLE the array is addressed straight from the request so that the
  // registered read lands in the following LOOKUP/WR_REQ cycle.
  assign rd_idx = (state_reg == DC_IDLE) ? dcache_addr[2+IDX_W-1:2] : waddr_reg[IDX_W-1:0];

  always_comb begin
    state_next    = state_reg;
    dcache_accept = 1'b0;
    case (state_reg)
      DC_INIT: begin
        if (cnt_reg == IDX_W'(LINES - 1)) state_next = DC_IDLE;
      end
      DC_IDLE: begin
        if (inv_any) begin
          state_next = DC_INIT;
        end else if (is_store) begin
          dcache_accept = 1'b1;
          state_next    = DC_WR_REQ;
        end else if (is_load) begin
          dcache_accept = 1'b1;
          state_next    = DC_LOOKUP;
        end
      end
      DC_LOOKUP:    state_next = hit ? DC_RESP : DC_MISS_REQ;
      DC_MISS_REQ:  if (mem_ack) state_next = DC_MISS_WAIT;
      DC_MISS_WAIT: if (mem_rvalid) state_next = DC_RESP;
      DC_RESP:      state_next = DC_IDLE;
      DC_WR_REQ:    if (mem_ack) state_next = DC_WR_DONE;
      DC_WR_DONE:   state_next = DC_IDLE;
      default:      state_next = DC_INIT;
    endcase
  end

  // Array writes: full-line fill on a miss return, byte merge on a store hit.
  always_comb begin
    wr_en   = 1'b0;
    wr_be   = '0;
    wr_data = wdata_reg;
    if (!srst) begin
      if (state_reg == DC_MISS_WAIT && mem_rvalid) begin
        wr_en   = 1'b1;
        wr_be   = '1;
        wr_data = mem_rdata;
      end else if (state_reg == DC_WR_REQ && mem_ack && hit) begin
        wr_en = 1'b1;
        wr_be = be_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg    <= DC_INIT;
      cnt_reg      <= '0;
      inv_pend_reg <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DC_INIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // Leaving IDLE either services the pending sweep or never needed it.
      if (state_reg == DC_IDLE) begin
        inv_pend_reg <= 1'b0;
      end else if (dcache_invalidate && state_reg != DC_INIT) begin
        inv_pend_reg <= 1'b1;
      end
      if (dcache_accept) begin
        waddr_reg <= dcache_addr[31:2];
        wdata_reg <= dcache_wdata;
        be_reg    <= dcache_write_request;
      end
      if (state_reg == DC_LOOKUP && hit) begin
        rdata_reg <= arr_data;
      end else if (state_reg == DC_MISS_WAIT && mem_rvalid) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  riscv_dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rd_idx   (rd_idx),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (wr_en),
    .wr_idx   (waddr_reg[IDX_W-1:0]),
    .wr_be    (wr_be),
    .wr_tag   (waddr_reg[29:IDX_W]),
    .wr_data  (wr_data),
    .clr_en   (state_reg == DC_INIT),
    .clr_idx  (cnt_reg)
  );

  assign dcache_busy        = (state_reg != DC_IDLE);
  assign dcache_rdata_valid = (state_reg == DC_RESP);
  assign dcache_wdata_valid = (state_reg == DC_WR_DONE);
  assign dcache_rdata       = rdata_reg;
  assign mem_req            = (state_reg == DC_MISS_REQ) || (state_reg == DC_WR_REQ);
  assign mem_we             = (state_reg == DC_WR_REQ);
  assign mem_be             = (state_reg == DC_WR_REQ) ? be_reg : '0;
  assign mem_addr           = {waddr_reg, 2'b00};
  assign mem_wdata          = wdata_reg;

endmodule

// File: tb/tb_riscv_dcache.sv
// Scoreboard bench for riscv_dcache: a line/memory reference model predicts
// each response and every memory request; a monitor checks completions.
module tb_riscv_dcache;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        dcache_read_request = 1'b0;
  logic [3:0]  dcache_write_request = 4'd0;
  logic [31:0] dcache_addr = 32'd0;
  logic [31:0] dcache_wdata = 32'd0;
  logic        dcache_accept, dcache_busy, dcache_rdata_valid, dcache_wdata_valid;
  logic [31:0] dcache_rdata;
  logic        dcache_invalidate = 1'b0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] last_rdata = 32'd0;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [int unsigned];
  bit          m_valid [LINES];
  logic [29:0] m_waddr [LINES];

  riscv_dcache #(.LINES(LINES)) dut (
    .clk                  (clk),
    .srst                 (srst),
    .dcache_read_request  (dcache_read_request),
    .dcache_write_request (dcache_write_request),
    .dcache_addr          (dcache_addr),
    .dcache_wdata         (dcache_wdata),
    .dcache_accept        (dcache_accept),
    .dcache_busy          (dcache_busy),
    .dcache_rdata_valid   (dcache_rdata_valid),
    .dcache_wdata_valid   (dcache_wdata_valid),
    .dcache_rdata         (dcache_rdata),
    .dcache_invalidate    (dcache_invalidate),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_be               (mem_be),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_model.exists(int'(wa))) return mem_model[int'(wa)];
    return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Completion monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (dcache_rdata_valid || dcache_wdata_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: rvalid=%0b wvalid=%0b, required no response", dcache_rdata_valid, dcache_wdata_valid);
      end else begin
        e = sb.pop_front();
        check("resp_kind", {30'd0, dcache_rdata_valid, dcache_wdata_valid}, e.rd ? 32'd2 : 32'd1);
        check("resp_cycle", cyc, e.cyc);
        if (e.rd) begin
          check("rdata", dcache_rdata, e.data);
          last_rdata = e.data;
        end else begin
          check("rdata_hold", dcache_rdata, last_rdata);
        end
        $display("[TB] %s complete at cycle %0d rdata=%h", e.rd ? "load " : "store", cyc, dcache_rdata);
      end
      done_cnt++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (dcache_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", (n >= 300) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    bit stray = 1'b0;
    #1;
    while (done_cnt < target && n < 60) begin
      if (mem_req) stray = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    check("done_timeout", (n >= 60) ? 32'd1 : 32'd0, 32'd0);
    check("stray_mem_req", {31'd0, stray}, 32'd0);
  endtask

  task automatic count_sweep(input string nm);
    int n = 0;
    int bad = 0;
    while (dcache_busy && n < 200) begin
      if (dcache_accept || dcache_rdata_valid || dcache_wdata_valid || mem_req) bad++;
      dcache_read_request = (n < 60);
      dcache_addr = $urandom;
      n++;
      @(negedge clk);
    end
    dcache_read_request = 1'b0;
    check({nm, "_len"}, n, LINES);
    check({nm, "_quiet"}, bad, 0);
  endtask

  task automatic serve_read(input logic [29:0] wa, input int a, input int rv);
    int n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rd_req_seen", {31'd0, mem_req}, 32'd1);
    check("rd_we", {31'd0, mem_we}, 32'd0);
    check("rd_addr", mem_addr, {wa, 2'b00});
    repeat (a) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (rv - 1) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = mem_rd(wa);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  task automatic serve_write(input logic [29:0] wa, input logic [3:0] be, input logic [31:0] wd, input int a);
    int n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wr_req_seen", {31'd0, mem_req}, 32'd1);
    check("wr_we", {31'd0, mem_we}, 32'd1);
    check("wr_addr", mem_addr, {wa, 2'b00});
    check("wr_be", {28'd0, mem_be}, {28'd0, be});
    check("wr_wdata", mem_wdata, wd);
    repeat (a) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input int a, input int rv, input int inv_at);
    int          c;
    int          target;
    int          idx;
    logic [29:0] wa;
    bit          hit;
    exp_t        e;
    wait_idle();
    c = cyc;
    target = done_cnt + 1;
    dcache_read_request = 1'b1;
    dcache_addr = addr;
    #1;
    check("accept_load", {31'd0, dcache_accept}, 32'd1);
    wa  = addr[31:2];
    idx = int'(addr[7:2]);
    hit = m_valid[idx] && (m_waddr[idx] == wa);
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_waddr[idx] = wa;
    end
    e.rd   = 1'b1;
    e.data = mem_rd(wa);
    e.cyc  = hit ? c + 2 : c + 3 + a + rv;
    sb.push_back(e);
    if (inv_at > 0) begin
      fork
        begin
          repeat (inv_at) @(negedge clk);
          dcache_invalidate = 1'b1;
          @(negedge clk);
          dcache_invalidate = 1'b0;
        end
      join_none
    end
    @(negedge clk);
    dcache_read_request = 1'b0;
    dcache_addr = $urandom;
    if (!hit) serve_read(wa, a, rv);
    wait_done(target);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                          input int a, input bit both);
    int          c;
    int          target;
    logic [29:0] wa;
    logic [31:0] word;
    exp_t        e;
    wait_idle();
    c = cyc;
    target = done_cnt + 1;
    dcache_write_request = be;
    dcache_read_request = both;
    dcache_addr = addr;
    dcache_wdata = wd;
    #1;
    check("accept_store", {31'd0, dcache_accept}, 32'd1);
    wa = addr[31:2];
    word = mem_rd(wa);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
    end
    mem_model[int'(wa)] = word;
    e.rd   = 1'b0;
    e.data = 32'd0;
    e.cyc  = c + 2 + a;
    sb.push_back(e);
    @(negedge clk);
    dcache_write_request = 4'd0;
    dcache_read_request = 1'b0;
    dcache_wdata = $urandom;
    serve_write(wa, be, wd, a);
    wait_done(target);
  endtask

  task automatic inv_idle();
    wait_idle();
    dcache_invalidate = 1'b1;
    dcache_read_request = 1'b1;
    dcache_addr = $urandom;
    #1;
    check("inv_blocks_accept", {31'd0, dcache_accept}, 32'd0);
    clear_model();
    @(negedge clk);
    dcache_invalidate = 1'b0;
    dcache_read_request = 1'b0;
    count_sweep("inv_idle_sweep");
  endtask

  initial begin
    int n;
    int r;
    logic [31:0] addr;
    clear_model();
    mem_model[int'(30'h40)] = 32'hDEAD_BEEF;
    mem_model[int'(30'h80)] = 32'hCAFE_F00D;

    dcache_read_request = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, dcache_busy}, 32'd1);
    check("rst_accept", {31'd0, dcache_accept}, 32'd0);
    check("rst_rvalid", {31'd0, dcache_rdata_valid}, 32'd0);
    check("rst_wvalid", {31'd0, dcache_wdata_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rdata", dcache_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    dcache_read_request = 1'b0;
    srst = 1'b0;
    count_sweep("reset_sweep");

    do_load(32'h0000_0100, 0, 3, 0);
    do_load(32'h0000_0100, 0, 1, 0);
    check("hit_value", dcache_rdata, 32'hDEAD_BEEF);
    do_store(32'h0000_0100, 4'b0011, 32'h1234_5678, 0, 1'b0);
    do_load(32'h0000_0100, 0, 1, 0);
    check("merged_value", dcache_rdata, 32'hDEAD_5678);
    do_load(32'h0000_0200, 1, 2, 0);
    do_load(32'h0000_0100, 0, 2, 0);

    // Invalidate arriving during MISS_WAIT is deferred until the load finishes.
    do_load(32'h0000_0200, 0, 3, 3);
    clear_model();
    @(negedge clk);
    check("inv_idle_gap", {31'd0, dcache_busy}, 32'd0);
    @(negedge clk);
    count_sweep("inv_pend_sweep");
    wait_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("spurious_rvalid_idle", {31'd0, dcache_busy}, 32'd0);
    do_load(32'h0000_0200, 0, 2, 0);
    check("refill_value", dcache_rdata, 32'hCAFE_F00D);

    // Synchronous reset while a miss request is outstanding.
    wait_idle();
    dcache_read_request = 1'b1;
    dcache_addr = 32'h3000_0104;
    #1;
    check("accept_rst_load", {31'd0, dcache_accept}, 32'd1);
    @(negedge clk);
    dcache_read_request = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_case_req", {31'd0, mem_req}, 32'd1);
    srst = 1'b1;
    @(negedge clk);
    check("rst_drops_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_busy", {31'd0, dcache_busy}, 32'd1);
    srst = 1'b0;
    last_rdata = 32'd0;
    clear_model();
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    fork
      begin
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
      end
    join_none
    count_sweep("rst_mid_sweep");
    do_load(32'h3000_0104, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 15);
      addr = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (r == 0) begin
        inv_idle();
      end else if (r <= 6) begin
        do_store(addr, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end else begin
        do_load(addr, $urandom_range(0, 2), $urandom_range(1, 4), 0);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
